// File: rtl/bk_spi_pkg.sv
// Shared definitions for the byte-wide SPI master: state encoding, bit-count
// terminal value and the idle levels of the SPI pins.
package bk_spi_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_e;

  localparam logic [2:0] BIT_LAST  = 3'd7;
  localparam logic       MOSI_IDLE = 1'b1;
  localparam logic       SCLK_IDLE = 1'b0;

endpackage

// File: rtl/spi_byte_master_if.sv
// Core-side byte port plus SPI pins of spi_byte_master.
// The master modport is the SPI master's view; slave is the core/peripheral side.
interface spi_byte_master_if;

  logic       spi_wren;
  logic [7:0] spi_do;
  logic       spi_cs_n;
  logic [7:0] spi_di;
  logic       spi_dsr;
  logic       sclk;
  logic       mosi;
  logic       miso;
  logic       ss_n;

  modport master (
    input  spi_wren, spi_do, spi_cs_n, miso,
    output spi_di, spi_dsr, sclk, mosi, ss_n
  );

  modport slave (
    output spi_wren, spi_do, spi_cs_n, miso,
    input  spi_di, spi_dsr, sclk, mosi, ss_n
  );

endinterface

// File: rtl/spi_baudgen.sv
// SCLK generator: ce-qualified divider counting 0..CLKDIV-1, toggling sclk at
// terminal count and flagging the decision cycle of each edge with rise/fall.
module spi_baudgen
  import bk_spi_pkg::*;
#(
  parameter int CLKDIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic ce,
  input  logic run,
  output logic rise,
  output logic fall,
  output logic sclk
);

  localparam int                CNT_W    = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKDIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             tc;

  assign tc   = ce & run & (cnt_q == CNT_LAST);
  assign rise = tc & ~sclk;
  assign fall = tc & sclk;

  // Deasserting run parks the generator at phase 0 with sclk at its idle level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      sclk  <= SCLK_IDLE;
    end else if (ce) begin
      if (!run) begin
        cnt_q <= '0;
        sclk  <= SCLK_IDLE;
      end else if (tc) begin
        cnt_q <= '0;
        sclk  <= ~sclk;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/spi_byte_master.sv
// Byte-wide SPI master, mode 0, MSB first; registered pass-through of chip select.
// Optional SPI_MISO_SYNC_EN adds a 2-flop MISO synchronizer on the raw clk.
module spi_byte_master
  import bk_spi_pkg::*;
#(
  parameter int CLKDIV = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ce,
  spi_byte_master_if.master   bus
);

  spi_state_e state_q, state_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] di_q, di_d;
  logic [2:0] bit_q, bit_d;
  logic       dsr_q, dsr_d;
  logic       ss_q;
  logic       run, rise, fall, sclk;
  logic       miso_s;

`ifdef SPI_MISO_SYNC_EN
  logic [1:0] miso_sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) miso_sync_q <= 2'b11;
    else       miso_sync_q <= {miso_sync_q[0], bus.miso};
  end

  assign miso_s = miso_sync_q[1];
`else
  assign miso_s = bus.miso;
`endif

  assign run = (state_q == SHIFT);

  spi_baudgen #(.CLKDIV(CLKDIV)) u_baudgen (
    .clk   (clk),
    .reset (reset),
    .ce    (ce),
    .run   (run),
    .rise  (rise),
    .fall  (fall),
    .sclk  (sclk)
  );

  // MOSI is the top of the tx register; shifting in ones leaves it at the
  // idle level once the eighth bit has gone out.
  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    di_d    = di_q;
    bit_d   = bit_q;
    dsr_d   = dsr_q;
    case (state_q)
      IDLE: begin
        if (ce && bus.spi_wren) begin
          tx_d    = bus.spi_do;
          bit_d   = '0;
          dsr_d   = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (rise) rx_d = {rx_q[6:0], miso_s};
        if (fall) begin
          tx_d  = {tx_q[6:0], MOSI_IDLE};
          bit_d = bit_q + 3'd1;
          if (bit_q == BIT_LAST) begin
            di_d    = rx_q;
            dsr_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      tx_q    <= 8'hFF;
      rx_q    <= 8'hFF;
      di_q    <= 8'hFF;
      bit_q   <= '0;
      dsr_q   <= 1'b1;
      ss_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      di_q    <= di_d;
      bit_q   <= bit_d;
      dsr_q   <= dsr_d;
      if (ce) ss_q <= bus.spi_cs_n;
    end
  end

  assign bus.spi_di  = di_q;
  assign bus.spi_dsr = dsr_q;
  assign bus.sclk    = sclk;
  assign bus.mosi    = tx_q[7];
  assign bus.ss_n    = ss_q;

endmodule

// File: tb/tb_spi_byte_master.sv
// Directed + randomized bench for spi_byte_master against a byte-level SPI model.
module tb_spi_byte_master;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic ce4   = 1'b1;
  logic ce2   = 1'b0;
  logic loop4 = 1'b1;
  logic miso_drv = 1'b1;

  int vectors     = 0;
  int miscompares = 0;

  spi_byte_master_if bus4 ();
  spi_byte_master_if bus2 ();

  spi_byte_master #(.CLKDIV(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .ce    (ce4),
    .bus   (bus4.master)
  );

  spi_byte_master #(.CLKDIV(2)) dut2 (
    .clk   (clk),
    .reset (reset),
    .ce    (ce2),
    .bus   (bus2.master)
  );

  always #5 clk = ~clk;

  always_comb bus4.miso = loop4 ? bus4.mosi : miso_drv;
  always_comb bus2.miso = bus2.mosi;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One byte on the CLKDIV=4 instance. A slave presents byte sl MSB first,
  // changing after each SCLK rise. Expected: MOSI carries tx MSB first, rises
  // at 4+8k clk after accept, spi_di = (loop ? tx : sl) 64 clk after accept.
  // mode 1: extra write at edge 20; mode 2: chip select toggled while busy;
  // mode 3: reset pulsed at edge 30.
  task automatic xfer4(input logic [7:0] tx, input logic [7:0] sl,
                       input logic loop, input int mode);
    logic [7:0] got_mosi;
    logic [7:0] exp_rx;
    logic       prev_sclk;
    int         rises;
    int         done_n;
    bit         aborted;
    got_mosi = '0;
    rises    = 0;
    done_n   = -1;
    aborted  = 1'b0;
    exp_rx   = loop ? tx : sl;
    loop4    = loop;
    miso_drv = sl[7];
    bus4.spi_do   = tx;
    bus4.spi_wren = 1'b1;
    @(posedge clk); #1;
    bus4.spi_wren = 1'b0;
    bus4.spi_do   = 8'($urandom);
    chk("dsr_busy", {31'd0, bus4.spi_dsr}, 32'd0);
    prev_sclk = bus4.sclk;
    for (int n = 1; n <= 200 && done_n < 0; n++) begin
      @(posedge clk); #1;
      if (bus4.sclk && !prev_sclk) begin
        chk("rise_time", n, 4 + 8 * rises);
        got_mosi = {got_mosi[6:0], bus4.mosi};
        rises++;
        if (rises < 8) miso_drv = sl[7 - rises];
      end
      prev_sclk = bus4.sclk;
      if (bus4.spi_dsr) done_n = n;
      if (mode == 1 && n == 19) begin
        bus4.spi_wren = 1'b1;
        bus4.spi_do   = 8'h3C;
      end
      if (mode == 1 && n == 20) bus4.spi_wren = 1'b0;
      if (mode == 2 && n == 10) bus4.spi_cs_n = 1'b0;
      if (mode == 2 && n == 11) chk("ss_busy_low", {31'd0, bus4.ss_n}, 32'd0);
      if (mode == 2 && n == 30) bus4.spi_cs_n = 1'b1;
      if (mode == 2 && n == 31) chk("ss_busy_high", {31'd0, bus4.ss_n}, 32'd1);
      if (mode == 3 && n == 30) begin
        chk("pre_reset_sclk", {31'd0, bus4.sclk}, 32'd1);
        reset = 1'b1;
        #2;
        chk("rst_sclk", {31'd0, bus4.sclk},    32'd0);
        chk("rst_mosi", {31'd0, bus4.mosi},    32'd1);
        chk("rst_ss_n", {31'd0, bus4.ss_n},    32'd1);
        chk("rst_di",   {24'd0, bus4.spi_di},  32'hFF);
        chk("rst_dsr",  {31'd0, bus4.spi_dsr}, 32'd1);
        aborted = 1'b1;
      end
      if (aborted) break;
    end
    if (!aborted) begin
      chk("done_time",  done_n, 64);
      chk("rise_count", rises, 8);
      chk("mosi_bits",  {24'd0, got_mosi}, {24'd0, tx});
      chk("spi_di",     {24'd0, bus4.spi_di}, {24'd0, exp_rx});
      chk("mosi_idle",  {31'd0, bus4.mosi}, 32'd1);
      chk("sclk_idle",  {31'd0, bus4.sclk}, 32'd0);
    end
  endtask

  initial begin
    logic [7:0] tx2;
    logic       prev2;
    int         r2 [2];
    int         nr2;
    int         done2;

    bus4.spi_wren = 1'b0;
    bus4.spi_do   = 8'h00;
    bus4.spi_cs_n = 1'b1;
    bus2.spi_wren = 1'b0;
    bus2.spi_do   = 8'h00;
    bus2.spi_cs_n = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_sclk", {31'd0, bus4.sclk},    32'd0);
    chk("reset_mosi", {31'd0, bus4.mosi},    32'd1);
    chk("reset_ss_n", {31'd0, bus4.ss_n},    32'd1);
    chk("reset_di",   {24'd0, bus4.spi_di},  32'hFF);
    chk("reset_dsr",  {31'd0, bus4.spi_dsr}, 32'd1);
    reset = 1'b0;
    @(posedge clk); #1;

    // Loopback A5, then back-to-back FF against a slave holding MISO low.
    xfer4(8'hA5, 8'h00, 1'b1, 0);
    xfer4(8'hFF, 8'h00, 1'b0, 0);

    for (int i = 0; i < 6; i++)
      xfer4(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 0);

    // Chip select while idle.
    bus4.spi_cs_n = 1'b0;
    #1 chk("ss_idle_hold", {31'd0, bus4.ss_n}, 32'd1);
    @(posedge clk); #1;
    chk("ss_idle_low", {31'd0, bus4.ss_n}, 32'd0);
    bus4.spi_cs_n = 1'b1;
    @(posedge clk); #1;
    chk("ss_idle_high", {31'd0, bus4.ss_n}, 32'd1);

    xfer4(8'($urandom), 8'($urandom), 1'b0, 2);
    xfer4(8'h81, 8'h00, 1'b1, 1);

    // Reset mid-transfer with chip select asserted.
    bus4.spi_cs_n = 1'b0;
    @(posedge clk); #1;
    chk("ss_before_reset", {31'd0, bus4.ss_n}, 32'd0);
    xfer4(8'h81, 8'h00, 1'b1, 3);
    @(posedge clk); #1;
    reset = 1'b0;
    bus4.spi_cs_n = 1'b1;
    @(posedge clk); #1;
    xfer4(8'($urandom), 8'($urandom), 1'b0, 0);

    // CLKDIV=2 instance with ce every third clk: 32 ce cycles busy = 96 clk.
    tx2 = 8'($urandom);
    bus2.spi_do   = tx2;
    bus2.spi_wren = 1'b1;
    ce2 = 1'b1;
    @(posedge clk); #1;
    bus2.spi_wren = 1'b0;
    ce2   = 1'b0;
    prev2 = bus2.sclk;
    nr2   = 0;
    done2 = -1;
    r2[0] = -1;
    r2[1] = -1;
    for (int n = 1; n <= 400 && done2 < 0; n++) begin
      @(posedge clk); #1;
      if (bus2.sclk && !prev2) begin
        if (nr2 < 2) r2[nr2] = n;
        nr2++;
      end
      prev2 = bus2.sclk;
      if (bus2.spi_dsr) done2 = n;
      ce2 = ((n + 1) % 3 == 0);
    end
    ce2 = 1'b0;
    chk("ce_first_rise", r2[0], 6);
    chk("ce_sclk_period", r2[1] - r2[0], 12);
    chk("ce_rises", nr2, 8);
    chk("ce_busy_time", done2, 96);
    chk("ce_spi_di", {24'd0, bus2.spi_di}, {24'd0, tx2});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
